ysyx_22041412_idu_pipe: RTL and testbench
=========================================

Name: ysyx_22041412_idu_pipe

Overview:
Registered, parametrised instruction-decode stage between IFU and EXU. It accepts one fetched instruction and PC per cycle over a valid/ready handshake. It decodes the instruction into operand-select, register-index and immediate fields, plus illegal-instruction and multiply flags. Results are held in a 2-entry skid buffer, so the stage sustains full throughput under backpressure and supports pipeline flush.

Parameters:
XLEN, 64, datapath width for imm and pc (32 or 64 only)
RV64, 1, 1 = OP-IMM-32 (0011011) and OP-32 (0111011) legal; 0 = these opcodes flagged illegal
MEXT, 1, 1 = mul_en asserted for OP/OP-32 with instr[25]=1; 0 = mul_en tied 0 and such instructions flagged illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all buffered and incoming instructions
in_valid  in  1  IFU has an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded entry available
out_ready  in  1  EXU accepts entry
out_pc  out  XLEN  PC of entry
out_opcode  out  7  instr[6:0]
out_func3  out  3  instr[14:12]
out_func7  out  1  instr[30]
out_rs1  out  5  source 1 index (0 for U/J)
out_rs2  out  5  source 2 index (0 for I/U/J)
out_rd  out  5  dest index (0 for S/B)
out_imm  out  XLEN  sign-extended immediate
out_v1type  out  2  00 = rs1, 01 = pc, 10 = zimm
out_v2type  out  2  00 = imm, 01 = rs2
out_mul_en  out  1  M-extension op
out_illegal  out  1  illegal encoding

Behaviour:
- Reset (async, immediate): both entries invalid; out_valid=0; in_ready=1; all data outputs 0.
- Decode is combinational on in_instr. Its result is captured into the main entry, or into the skid entry if main is occupied and not draining. Latency: accept at edge N gives out_valid at N+1.
- Classes:
  - I: jalr, load, OP-IMM, OP-IMM-32, SYSTEM
  - U: lui, auipc
  - J: jal
  - B: branch
  - S: store
  - R: OP, OP-32
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - U: {instr[31:12], 12'b0}
  - J: {instr[19:12], instr[20], instr[30:21], 0}
  - B: {instr[7], instr[30:25], instr[11:8], 0}
  - S: {instr[31:25], instr[11:7]}
  - otherwise 0
- v1type: pc for jal and auipc; zimm for SYSTEM with func3 in {101, 110, 111}; else rs1.
- v2type: rs2 for R and B; else imm.
- mul_en: R class AND instr[25]=1 AND MEXT=1.
- illegal is set when any of the following holds:
  - instr[1:0] != 11
  - opcode not in the 12 listed classes
  - RV64=0 and opcode is a 32-bit-W opcode
  - MEXT=0 and mul condition met
- An illegal entry still flows downstream with illegal=1, and rs1/rs2/rd/imm/mul_en forced to 0.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = !skid_valid, registered (no combinational in_ready-from-out_ready path).
  - When main drains, skid moves to main in the same edge.
  - A new accept and a drain in the same cycle must both occur; there is no bubble.
  - Output fields are stable while out_valid && !out_ready.
- Flush has priority over everything:
  - Both entries are invalidated at the edge.
  - An instruction presented in the flush cycle is dropped, even if in_valid && in_ready.
  - in_ready=1 and out_valid=0 on the next cycle.
- Reset asserted mid-stream clears state immediately, regardless of handshake.
- Unused upper data bits for XLEN=32 do not exist; pc passes through unchanged.

Test Plan:
- 0xFFF10093 (addi x1,x2,-1), pc=0x80000000, out_ready=1 → next cycle: out_valid=1, rs1=2, rs2=0, rd=1, imm=0xFFFFFFFFFFFFFFFF, v1=00, v2=00, illegal=0, out_pc=0x80000000.
- 0x800002B7 (lui x5,0x80000) → rs1=0, rd=5, imm=0xFFFFFFFF80000000; with XLEN=32 → imm=0x80000000.
- 0x022081B3 (mul x3,x1,x2) → mul_en=1, v2=01, rs1=1, rs2=2, rd=3. With MEXT=0 → illegal=1, all indices 0.
- 0x0020A423 (sw x2,8(x1)) → imm=8, rd=0, rs2=2, v2=00. Also 0x00000000 → illegal=1, imm=0.
- Backpressure: out_ready=0, push 3 back-to-back instructions → first two accepted, in_ready=0 on the third. Then out_ready=1 → entries emerge in order with no loss or duplication and no bubble at full throughput.
- With 2 entries buffered, assert flush for 1 cycle while in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed-cycle instruction never appears. Async rst pulse mid-cycle → out_valid drops before the next edge.

Source files
------------

// File: rtl/ysyx_22041412_idu_pipe.sv
// ysyx_22041412_idu_pipe
// Registered instruction-decode stage sitting between IFU and EXU.
// Each accepted instruction is decoded combinationally and captured into a
// 2-entry skid buffer (main + skid), so the stage keeps full throughput under
// backpressure while in_ready stays a pure register output.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flush                drops both buffered entries and the incoming instruction
//   in_valid/in_ready    IFU handshake; in_instr (32b) and in_pc (XLEN) payload
//   out_valid/out_ready  EXU handshake
//   out_pc               PC of the presented entry
//   out_opcode/func3/func7  raw instr[6:0], instr[14:12], instr[30]
//   out_rs1/rs2/rd       register indices (zeroed when unused by the format)
//   out_imm              sign-extended immediate
//   out_v1type           00 rs1, 01 pc, 10 zimm
//   out_v2type           00 imm, 01 rs2
//   out_mul_en           M-extension operation
//   out_illegal          illegal encoding (indices/imm/mul_en forced to 0)
module ysyx_22041412_idu_pipe #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RV64 = 1,
    parameter int unsigned MEXT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic            out_func7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [1:0]      out_v1type,
    output logic [1:0]      out_v2type,
    output logic            out_mul_en,
    output logic            out_illegal
);

    localparam logic P_RV64 = (RV64 != 0);
    localparam logic P_MEXT = (MEXT != 0);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [1:0]      v1type;
        logic [1:0]      v2type;
        logic            mul_en;
        logic            illegal;
    } entry_t;

    // ---------------------------------------------------------------- decode
    logic [6:0]  w_op;
    logic        w_cls_i, w_cls_u, w_cls_j, w_cls_b, w_cls_s, w_cls_r;
    logic        w_known, w_wop, w_mul_cond, w_zimm, w_illegal;
    logic [31:0] w_imm32;
    entry_t      w_dec;

    assign w_op    = in_instr[6:0];
    assign w_cls_i = (w_op == OP_JALR) || (w_op == OP_LOAD) || (w_op == OP_IMM)
                  || (w_op == OP_IMM32) || (w_op == OP_SYSTEM);
    assign w_cls_u = (w_op == OP_LUI) || (w_op == OP_AUIPC);
    assign w_cls_j = (w_op == OP_JAL);
    assign w_cls_b = (w_op == OP_BRANCH);
    assign w_cls_s = (w_op == OP_STORE);
    assign w_cls_r = (w_op == OP_OP) || (w_op == OP_OP32);

    assign w_known    = w_cls_i || w_cls_u || w_cls_j || w_cls_b || w_cls_s || w_cls_r;
    assign w_wop      = (w_op == OP_IMM32) || (w_op == OP_OP32);
    assign w_mul_cond = w_cls_r && in_instr[25];
    assign w_zimm     = (w_op == OP_SYSTEM) && (in_instr[14:12] >= 3'b101);
    assign w_illegal  = (in_instr[1:0] != 2'b11) || !w_known
                     || (!P_RV64 && w_wop) || (!P_MEXT && w_mul_cond);

    // 32-bit sign-extended immediate; widened to XLEN by a signed cast below
    always_comb begin
        w_imm32 = '0;
        if (w_cls_i)
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (w_cls_u)
            w_imm32 = {in_instr[31:12], 12'b0};
        else if (w_cls_j)
            w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        else if (w_cls_b)
            w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        else if (w_cls_s)
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    end

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = w_op;
        w_dec.func3   = in_instr[14:12];
        w_dec.func7   = in_instr[30];
        w_dec.illegal = w_illegal;

        if (w_cls_j || w_op == OP_AUIPC)
            w_dec.v1type = 2'b01;
        else if (w_zimm)
            w_dec.v1type = 2'b10;
        w_dec.v2type = (w_cls_r || w_cls_b) ? 2'b01 : 2'b00;

        // Illegal entries still travel downstream but carry no operands
        if (!w_illegal) begin
            if (!(w_cls_u || w_cls_j))
                w_dec.rs1 = in_instr[19:15];
            if (w_cls_r || w_cls_b || w_cls_s)
                w_dec.rs2 = in_instr[24:20];
            if (!(w_cls_s || w_cls_b))
                w_dec.rd = in_instr[11:7];
            w_dec.imm    = XLEN'($signed(w_imm32));
            w_dec.mul_en = w_mul_cond && P_MEXT;
        end
    end

    // ----------------------------------------------------------- skid buffer
    entry_t r_main, r_skid;
    logic   r_main_valid, r_skid_valid;
    logic   w_accept;

    // in_ready depends only on the skid register, never on out_ready
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            // Main is empty or draining. A full skid implies in_ready=0, so the
            // skid refill and a new accept can never collide here.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept)
                    r_main <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_main_valid;
    assign out_pc      = r_main.pc;
    assign out_opcode  = r_main.opcode;
    assign out_func3   = r_main.func3;
    assign out_func7   = r_main.func7;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd      = r_main.rd;
    assign out_imm     = r_main.imm;
    assign out_v1type  = r_main.v1type;
    assign out_v2type  = r_main.v2type;
    assign out_mul_en  = r_main.mul_en;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_ysyx_22041412_idu_pipe.sv
module tb_ysyx_22041412_idu_pipe;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [1:0]  v1;
        logic [1:0]  v2;
        logic        mul;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b0;

    // default-parameter DUT (XLEN=64, RV64=1, MEXT=1)
    logic        a_in_ready, a_out_valid, a_f7, a_mul, a_ill;
    logic [63:0] a_pc, a_imm;
    logic [6:0]  a_op;
    logic [2:0]  a_f3;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [1:0]  a_v1, a_v2;

    // reduced DUT (XLEN=32, RV64=0, MEXT=0) fed the same stimulus
    logic        b_in_ready, b_out_valid, b_f7, b_mul, b_ill;
    logic [31:0] b_pc, b_imm;
    logic [6:0]  b_op;
    logic [2:0]  b_f3;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [1:0]  b_v1, b_v2;

    exp_t act64, act32;
    assign act64 = {a_pc, a_op, a_f3, a_f7, a_rs1, a_rs2, a_rd, a_imm, a_v1, a_v2, a_mul, a_ill};
    assign act32 = {32'b0, b_pc, b_op, b_f3, b_f7, b_rs1, b_rs2, b_rd, 32'b0, b_imm, b_v1, b_v2, b_mul, b_ill};

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ysyx_22041412_idu_pipe dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_opcode(a_op), .out_func3(a_f3), .out_func7(a_f7),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_v1type(a_v1), .out_v2type(a_v2), .out_mul_en(a_mul), .out_illegal(a_ill)
    );

    ysyx_22041412_idu_pipe #(.XLEN(32), .RV64(0), .MEXT(0)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_opcode(b_op), .out_func3(b_f3), .out_func7(b_f7),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_v1type(b_v1), .out_v2type(b_v2), .out_mul_en(b_mul), .out_illegal(b_ill)
    );

    function automatic exp_t mk(logic [63:0] pc, logic [6:0] op, logic [2:0] f3, logic f7,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [63:0] imm,
                                logic [1:0] v1, logic [1:0] v2, logic mul, logic ill);
        exp_t e;
        e = '{pc, op, f3, f7, rs1, rs2, rd, imm, v1, v2, mul, ill};
        return e;
    endfunction

    // Reference decode for XLEN=64, RV64=1, MEXT=1, organised per opcode
    function automatic exp_t model(logic [31:0] ins, logic [63:0] pc);
        exp_t e;
        logic [63:0] sx;
        sx = {64{ins[31]}};
        e = '0;
        e.pc = pc; e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[30];
        case (ins[6:0])
            7'h37: begin e.rd = ins[11:7]; e.imm = {sx[63:32], ins[31:12], 12'h000}; end
            7'h17: begin e.rd = ins[11:7]; e.imm = {sx[63:32], ins[31:12], 12'h000}; e.v1 = 2'b01; end
            7'h6F: begin
                e.rd = ins[11:7]; e.v1 = 2'b01;
                e.imm = {sx[63:21], ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h67, 7'h03, 7'h13, 7'h1B, 7'h73: begin
                e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = {sx[63:12], ins[31:20]};
                if (ins[6:0] == 7'h73 && (ins[14:12] == 3'd5 || ins[14:12] == 3'd6 || ins[14:12] == 3'd7))
                    e.v1 = 2'b10;
            end
            7'h63: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.v2 = 2'b01;
                e.imm = {sx[63:13], ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h23: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = {sx[63:12], ins[31:25], ins[11:7]};
            end
            7'h33, 7'h3B: begin
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.v2 = 2'b01; e.mul = ins[25];
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [13];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h73, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 12)];
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        checks++; if (act64 !== exp_t'(0)) begin errors++; $display("FAIL reset_data64: got %h want 0", act64); end
        checks++; if (act32 !== exp_t'(0) || b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dut32: got %h v=%b want 0", act32, b_out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [7];
        exp_t e64 [7];
        exp_t e32 [7];
        logic [63:0] pc;
        ins = '{32'hFFF10093, 32'h800002B7, 32'h022081B3, 32'h0020A423, 32'h00000000, 32'h002081BB, 32'h3002D073};
        for (int unsigned i = 0; i < 7; i++) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            case (i)
                0: begin e64[i] = mk(pc, 7'h13, 3'd0, 1'b1, 5'd1 * 2, 5'd0, 5'd1, '1, 2'd0, 2'd0, 1'b0, 1'b0);
                          e32[i] = mk(pc, 7'h13, 3'd0, 1'b1, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF, 2'd0, 2'd0, 1'b0, 1'b0); end
                1: begin e64[i] = mk(pc, 7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_8000_0000, 2'd0, 2'd0, 1'b0, 1'b0);
                          e32[i] = mk(pc, 7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 64'h8000_0000, 2'd0, 2'd0, 1'b0, 1'b0); end
                2: begin e64[i] = mk(pc, 7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 64'd0, 2'd0, 2'd1, 1'b1, 1'b0);
                          e32[i] = mk(pc, 7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd1, 1'b0, 1'b1); end
                3: begin e64[i] = mk(pc, 7'h23, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 64'd8, 2'd0, 2'd0, 1'b0, 1'b0);
                          e32[i] = e64[i]; end
                4: begin e64[i] = mk(pc, 7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd0, 1'b0, 1'b1);
                          e32[i] = e64[i]; end
                5: begin e64[i] = mk(pc, 7'h3B, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 64'd0, 2'd0, 2'd1, 1'b0, 1'b0);
                          e32[i] = mk(pc, 7'h3B, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 2'd0, 2'd1, 1'b0, 1'b1); end
                default: begin e64[i] = mk(pc, 7'h73, 3'd5, 1'b0, 5'd5, 5'd0, 5'd0, 64'h300, 2'd2, 2'd0, 1'b0, 1'b0);
                          e32[i] = e64[i]; end
            endcase
            // back-to-back: each new instruction is offered while the previous drains
            in_valid = 1'b1; in_instr = ins[i]; in_pc = pc; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid[%0d]: got %b/%b want 1/1", i, a_out_valid, b_out_valid); end
            checks++; if (act64 !== e64[i]) begin errors++; $display("FAIL decode64[%0d]: got %h want %h", i, act64, e64[i]); end
            checks++; if (act32 !== e32[i]) begin errors++; $display("FAIL decode32[%0d]: got %h want %h", i, act32, e32[i]); end
        end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL decode_drained: got %b want 0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3];
        logic [63:0] pcs [3];
        ins = '{32'h00500113, 32'h40208233, 32'hFE000EE3};
        pcs = '{64'h1000, 64'h1004, 64'h1008};
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = ins[0]; in_pc = pcs[0];
        @(posedge clk); #1;
        in_instr = ins[1]; in_pc = pcs[1];
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_1: got %b want 1", a_in_ready); end
        @(posedge clk); #1;
        in_instr = ins[2]; in_pc = pcs[2];
        checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b/%b want 0/0", a_in_ready, b_in_ready); end
        @(posedge clk); #1;
        checks++; if (a_in_ready !== 1'b0 || act64 !== model(ins[0], pcs[0])) begin errors++; $display("FAIL bp_stable: ready %b got %h want %h", a_in_ready, act64, model(ins[0], pcs[0])); end
        out_ready = 1'b1;
        for (int unsigned k = 1; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) in_valid = 1'b0;
            checks++; if (a_out_valid !== 1'b1 || act64 !== model(ins[k], pcs[k])) begin errors++; $display("FAIL bp_order[%0d]: v=%b got %h want %h", k, a_out_valid, act64, model(ins[k], pcs[k])); end
        end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_empty: got v=%b r=%b want 0/1", a_out_valid, a_in_ready); end
    endtask

    task automatic run_traffic(input int unsigned cycles, input int unsigned vpct, input int unsigned rpct, input string name);
        exp_t e;
        int unsigned bubbles;
        sb.delete();
        bubbles = 0;
        for (int unsigned c = 0; c < cycles + 12; c++) begin
            if (c < cycles) begin
                in_valid  = ($urandom_range(1, 100) <= vpct);
                out_ready = ($urandom_range(1, 100) <= rpct);
                in_instr  = rand_instr();
                in_pc     = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #3;
            if (c > 0 && c < cycles && !a_out_valid) bubbles++;
            if (a_out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL %s_extra: got %h want nothing", name, act64);
                end else begin
                    e = sb.pop_front();
                    if (act64 !== e) begin errors++; $display("FAIL %s_data: got %h want %h", name, act64, e); end
                end
            end
            if (in_valid && a_in_ready) sb.push_back(model(in_instr, in_pc));
            @(posedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL %s_lost: got %0d left want 0", name, sb.size()); end
        if (vpct == 100 && rpct == 100) begin
            checks++; if (bubbles != 0) begin errors++; $display("FAIL %s_bubbles: got %0d want 0", name, bubbles); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h2000;
        @(posedge clk); #1 in_instr = 32'h00200113; in_pc = 64'h2004;
        @(posedge clk); #1;
        flush = 1'b1; in_instr = 32'h00300193; in_pc = 64'h2008;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin errors++; $display("FAIL flush_full: got v=%b r=%b v32=%b want 0/1/0", a_out_valid, a_in_ready, b_out_valid); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_ghost: got %b want 0", a_out_valid); end
        // one entry held, so in_ready is high while flush and in_valid coincide
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 64'h3000;
        @(posedge clk); #1;
        flush = 1'b1; in_instr = 32'h00500293; in_pc = 64'h3004;
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got r=%b v=%b want 1/1", a_in_ready, a_out_valid); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_drop: got v=%b r=%b want 0/1", a_out_valid, a_in_ready); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_ghost: got %b want 0", a_out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h4000;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", a_out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || act64 !== exp_t'(0)) begin errors++; $display("FAIL arst_immediate: got v=%b r=%b d=%h want 0/1/0", a_out_valid, a_in_ready, act64); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL arst_after: got %b want 0", a_out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        run_traffic(300, 70, 60, "random");
        run_traffic(40, 100, 100, "back_to_back");
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
